// File: rtl/nn_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and
// activation-datapath select codes.
package nn_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_IN,
      ST_START,
      ST_WAIT,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } seq_state_t;

   localparam logic [1:0] ACT_IDLE     = 2'b00;
   localparam logic [1:0] ACT_FEEDBACK = 2'b01;
   localparam logic [1:0] ACT_OUTPUT   = 2'b10;

   // A run is in progress in every state except the three resting ones.
   function automatic logic is_active(input seq_state_t s);
      return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
   endfunction

endpackage

// File: rtl/nn_sequencer_seq_counter.sv
// Clearable up-counter that saturates at all-ones instead of wrapping.
module seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/nn_sequencer.sv
// Layer sequencer: walks weight load, input load, compute start and result
// collection for each layer, with a watchdog on the result wait.
module nn_sequencer #(
   parameter int W_CYCLES  = 2,
   parameter int IN_CYCLES = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seq_start,
   input  logic       seq_abort,
   input  logic [3:0] seq_num_layers,
   input  logic [3:0] seq_num_vectors,
   input  logic       seq_lr_valid_1,
   input  logic       seq_lr_valid_2,
   output logic       seq_load_weights,
   output logic       seq_load_inputs,
   output logic       seq_nn_start,
   output logic [1:0] seq_activation_datapath,
   output logic [3:0] seq_layer_idx,
   output logic       seq_busy,
   output logic       seq_done,
   output logic       seq_error
);
   import nn_sequencer_pkg::*;

   localparam int PH_MAX = (W_CYCLES > IN_CYCLES) ? W_CYCLES : IN_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   seq_state_t       state, state_next;
   logic [3:0]       cfg_layers, cfg_vectors, layers_next, layer_next;
   logic [1:0]       act_next;
   logic             accept_start, error_next;
   logic [PH_W-1:0]  phase_cnt;
   logic [3:0]       beat_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             phase_clr, phase_inc, wait_clr, beat_inc, tmo_inc;

   // Column-1 valid carries no information for beat counting.
   logic unused_valid_1;
   assign unused_valid_1 = seq_lr_valid_1;

   seq_counter #(.WIDTH(PH_W)) u_phase_cnt (
      .clk(clk), .rst(rst), .clr(phase_clr), .inc(phase_inc), .count(phase_cnt)
   );
   seq_counter #(.WIDTH(4)) u_beat_cnt (
      .clk(clk), .rst(rst), .clr(wait_clr), .inc(beat_inc), .count(beat_cnt)
   );
   seq_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
      .clk(clk), .rst(rst), .clr(wait_clr), .inc(tmo_inc), .count(tmo_cnt)
   );

   always_comb begin
      state_next   = state;
      accept_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (seq_start) begin
               accept_start = 1'b1;
               state_next   = (seq_num_layers == 4'd0) ? ST_DONE : ST_LOAD_W;
            end
         end
         ST_LOAD_W: begin
            if (phase_cnt == PH_W'(W_CYCLES - 1)) begin
               state_next = (seq_layer_idx == 4'd0) ? ST_LOAD_IN : ST_START;
            end
         end
         ST_LOAD_IN: begin
            if (phase_cnt == PH_W'(IN_CYCLES - 1)) state_next = ST_START;
         end
         ST_START: state_next = ST_WAIT;
         // Beat completion wins over a timeout expiring in the same cycle.
         ST_WAIT: begin
            if (beat_cnt == cfg_vectors) begin
               state_next = ST_NEXT;
            end else if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
               state_next = ST_ERROR;
            end
         end
         ST_NEXT: begin
            state_next = (seq_layer_idx + 4'd1 == cfg_layers) ? ST_DONE : ST_LOAD_W;
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_ERROR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (seq_abort) begin
         state_next   = ST_IDLE;
         accept_start = 1'b0;
      end

      layers_next = accept_start ? seq_num_layers : cfg_layers;
      layer_next  = seq_layer_idx;
      if (seq_abort || accept_start) begin
         layer_next = 4'd0;
      end else if (state == ST_NEXT) begin
         layer_next = seq_layer_idx + 4'd1;
      end

      if (!is_active(state_next)) begin
         act_next = ACT_IDLE;
      end else if (({1'b0, layer_next} + 5'd1) < {1'b0, layers_next}) begin
         act_next = ACT_FEEDBACK;
      end else begin
         act_next = ACT_OUTPUT;
      end

      error_next = seq_error;
      if (accept_start) error_next = 1'b0;
      if (state_next == ST_ERROR) error_next = 1'b1;

      // Every state change restarts the phase count for the state entered.
      phase_clr = (state_next != state);
      phase_inc = (state == ST_LOAD_W) || (state == ST_LOAD_IN);
      wait_clr  = (state == ST_START);
      beat_inc  = (state == ST_WAIT) && seq_lr_valid_2;
      tmo_inc   = (state == ST_WAIT);
   end

   // Outputs are decoded from the next state so each enable rises together
   // with entry into the state that owns it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                   <= ST_IDLE;
         cfg_layers              <= 4'd0;
         cfg_vectors             <= 4'd0;
         seq_layer_idx           <= 4'd0;
         seq_load_weights        <= 1'b0;
         seq_load_inputs         <= 1'b0;
         seq_nn_start            <= 1'b0;
         seq_activation_datapath <= ACT_IDLE;
         seq_busy                <= 1'b0;
         seq_done                <= 1'b0;
         seq_error               <= 1'b0;
      end else begin
         state       <= state_next;
         cfg_layers  <= layers_next;
         if (accept_start) cfg_vectors <= seq_num_vectors;
         seq_layer_idx           <= layer_next;
         seq_load_weights        <= (state_next == ST_LOAD_W);
         seq_load_inputs         <= (state_next == ST_LOAD_IN);
         seq_nn_start            <= (state_next == ST_START);
         seq_activation_datapath <= act_next;
         seq_busy                <= is_active(state_next);
         seq_done                <= (state_next == ST_DONE);
         seq_error               <= error_next;
      end
   end

endmodule

// File: tb/tb_nn_sequencer.sv
// Randomized self-checking bench for nn_sequencer against a phase-level
// reference model of the expected output trace.
module tb_nn_sequencer;

   localparam int W_CYC  = 2;
   localparam int IN_CYC = 2;
   localparam int TMO    = 64;

   logic       clk;
   logic       rst;
   logic       seq_start, seq_abort, seq_lr_valid_1, seq_lr_valid_2;
   logic [3:0] seq_num_layers, seq_num_vectors;
   logic       seq_load_weights, seq_load_inputs, seq_nn_start;
   logic [1:0] seq_activation_datapath;
   logic [3:0] seq_layer_idx;
   logic       seq_busy, seq_done, seq_error;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic       busy;
      logic       lw;
      logic       li;
      logic       ns;
      logic [1:0] dp;
      logic [3:0] idx;
      logic       done;
      logic       err;
   } obs_t;

   obs_t exp_q[$];
   bit   v2_q[$];

   nn_sequencer #(.W_CYCLES(W_CYC), .IN_CYCLES(IN_CYC), .TIMEOUT(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .seq_start(seq_start),
      .seq_abort(seq_abort),
      .seq_num_layers(seq_num_layers),
      .seq_num_vectors(seq_num_vectors),
      .seq_lr_valid_1(seq_lr_valid_1),
      .seq_lr_valid_2(seq_lr_valid_2),
      .seq_load_weights(seq_load_weights),
      .seq_load_inputs(seq_load_inputs),
      .seq_nn_start(seq_nn_start),
      .seq_activation_datapath(seq_activation_datapath),
      .seq_layer_idx(seq_layer_idx),
      .seq_busy(seq_busy),
      .seq_done(seq_done),
      .seq_error(seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t mk(logic busy, logic lw, logic li, logic ns,
                               logic [1:0] dp, logic [3:0] idx, logic done);
      obs_t o;
      o = {busy, lw, li, ns, dp, idx, done, 1'b0};
      return o;
   endfunction

   function automatic obs_t actual();
      obs_t o;
      o = {seq_busy, seq_load_weights, seq_load_inputs, seq_nn_start,
           seq_activation_datapath, seq_layer_idx, seq_done, seq_error};
      return o;
   endfunction

   task automatic push(input obs_t o, input bit v2);
      exp_q.push_back(o);
      v2_q.push_back(v2);
   endtask

   // Per layer: W weight-load cycles, input load on layer 0 only, one start
   // pulse, then a wait whose length follows from the scheduled beats, one
   // more cycle to see the target met, and the layer-advance cycle.
   task automatic build_model(input int layers, input int vectors);
      exp_q.delete();
      v2_q.delete();
      for (int l = 0; l < layers; l++) begin
         logic [1:0] dp;
         logic [3:0] idx;
         obs_t       idle_wait;
         dp  = (l == layers - 1) ? 2'b10 : 2'b01;
         idx = 4'(l);
         idle_wait = mk(1'b1, 1'b0, 1'b0, 1'b0, dp, idx, 1'b0);
         repeat (W_CYC) push(mk(1'b1, 1'b1, 1'b0, 1'b0, dp, idx, 1'b0), 1'b0);
         if (l == 0) repeat (IN_CYC) push(mk(1'b1, 1'b0, 1'b1, 1'b0, dp, idx, 1'b0), 1'b0);
         push(mk(1'b1, 1'b0, 1'b0, 1'b1, dp, idx, 1'b0), 1'b0);
         for (int b = 0; b < vectors; b++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) push(idle_wait, 1'b0);
            push(idle_wait, 1'b1);
         end
         push(idle_wait, 1'b0);
         push(idle_wait, 1'b0);
      end
      push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'(layers), 1'b1), 1'b0);
      push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'(layers), 1'b0), 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_async: got %b want all zero", actual());
      end
      tick();
      tick();
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_held: got %b want all zero", actual());
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_release_idle: got %b want all zero", actual());
      end
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 8; r++) begin
         int layers, vectors;
         layers  = (r == 0) ? 1 : (r == 1) ? 3 : $urandom_range(1, 4);
         vectors = (r == 0) ? 2 : (r == 1) ? 1 : $urandom_range(0, 5);
         build_model(layers, vectors);
         seq_num_layers  = 4'(layers);
         seq_num_vectors = 4'(vectors);
         seq_start = 1'b1;
         tick();
         seq_start = 1'b0;
         for (int i = 0; i < exp_q.size(); i++) begin
            obs_t got;
            got = actual();
            compared++;
            if (got !== exp_q[i]) begin
               mismatched++;
               $display("[TB] FAIL trace L%0d V%0d cyc%0d: got busy=%b lw=%b li=%b ns=%b dp=%b idx=%0d done=%b err=%b, want busy=%b lw=%b li=%b ns=%b dp=%b idx=%0d done=%b err=%b",
                        layers, vectors, i, got.busy, got.lw, got.li, got.ns, got.dp, got.idx, got.done, got.err,
                        exp_q[i].busy, exp_q[i].lw, exp_q[i].li, exp_q[i].ns, exp_q[i].dp, exp_q[i].idx,
                        exp_q[i].done, exp_q[i].err);
            end
            seq_lr_valid_2 = v2_q[i];
            seq_lr_valid_1 = 1'($urandom_range(0, 1));
            seq_num_layers  = 4'($urandom);
            seq_num_vectors = 4'($urandom);
            seq_start = exp_q[i].busy && ($urandom_range(0, 3) == 0);
            tick();
         end
         seq_start = 1'b0;
         seq_lr_valid_1 = 1'b0;
         seq_lr_valid_2 = 1'b0;
      end
   endtask

   task automatic test_start_while_busy();
      int k;
      seq_num_layers  = 4'd1;
      seq_num_vectors = 4'd1;
      seq_start = 1'b1;
      tick();
      seq_num_layers  = 4'd3;
      seq_num_vectors = 4'd5;
      tick();
      seq_start = 1'b0;
      k = 0;
      while (seq_nn_start !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      tick();
      seq_lr_valid_2 = 1'b1;
      tick();
      seq_lr_valid_2 = 1'b0;
      k = 1;
      while (seq_done !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      compared++;
      if (k !== 3) begin
         mismatched++;
         $display("[TB] FAIL busy_start_done_latency: got %0d cycles want 3", k);
      end
      compared++;
      if (seq_layer_idx !== 4'd1) begin
         mismatched++;
         $display("[TB] FAIL busy_start_layer_count: got %0d want 1", seq_layer_idx);
      end
      tick();
      compared++;
      if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL busy_start_idle_after: got done=%b busy=%b want 0 0", seq_done, seq_busy);
      end
   endtask

   task automatic test_timeout();
      int k;
      seq_num_layers  = 4'd1;
      seq_num_vectors = 4'd2;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      k = 0;
      while (seq_nn_start !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      compared++;
      if (seq_nn_start !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL timeout_reach_start: got nn_start=%b want 1", seq_nn_start);
      end
      k = 0;
      while (seq_error !== 1'b1 && k < 200) begin
         seq_lr_valid_1 = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      seq_lr_valid_1 = 1'b0;
      compared++;
      if (k !== TMO + 1) begin
         mismatched++;
         $display("[TB] FAIL timeout_latency: got %0d cycles after start want %0d", k, TMO + 1);
      end
      compared++;
      if (seq_busy !== 1'b0 || seq_done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_state: got busy=%b done=%b want 0 0", seq_busy, seq_done);
      end
      tick();
      compared++;
      if (seq_error !== 1'b1 || seq_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL error_sticky: got err=%b busy=%b want 1 0", seq_error, seq_busy);
      end
      seq_abort = 1'b1;
      tick();
      seq_abort = 1'b0;
      compared++;
      if (seq_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_keeps_error: got %b want 1", seq_error);
      end
   endtask

   task automatic test_zero_layers();
      seq_num_layers  = 4'd0;
      seq_num_vectors = 4'($urandom);
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      compared++;
      if (actual() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1)) begin
         mismatched++;
         $display("[TB] FAIL zero_layers_done: got %b want %b", actual(),
                  mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1));
      end
      tick();
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL zero_layers_idle: got %b want all zero", actual());
      end
   endtask

   task automatic test_abort();
      int  k;
      bit  bad;
      // Abort in LOAD_W together with a start request.
      seq_num_layers  = 4'd2;
      seq_num_vectors = 4'd1;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      compared++;
      if (seq_load_weights !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_pre_loadw: got %b want 1", seq_load_weights);
      end
      seq_abort = 1'b1;
      seq_start = 1'b1;
      tick();
      seq_abort = 1'b0;
      seq_start = 1'b0;
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL abort_loadw: got %b want all zero", actual());
      end
      bad = 1'b0;
      repeat (4) begin
         tick();
         if (seq_done !== 1'b0 || seq_busy !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad) begin
         mismatched++;
         $display("[TB] FAIL abort_loadw_quiet: got activity want idle");
      end

      // Abort in WAIT.
      seq_num_vectors = 4'd3;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      k = 0;
      while (seq_nn_start !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      repeat (3) tick();
      seq_abort = 1'b1;
      tick();
      seq_abort = 1'b0;
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL abort_wait: got %b want all zero", actual());
      end
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (seq_done !== 1'b0 || seq_busy !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad) begin
         mismatched++;
         $display("[TB] FAIL abort_wait_quiet: got activity want idle");
      end

      // Reset asserted in WAIT.
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      k = 0;
      while (seq_nn_start !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      repeat (2) tick();
      rst = 1'b0;
      #1;
      compared++;
      if (actual() !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_wait: got %b want all zero", actual());
      end
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (seq_done !== 1'b0 || seq_busy !== 1'b0) bad = 1'b1;
      end
      compared++;
      if (bad) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_wait_quiet: got activity want idle");
      end
   endtask

   initial begin
      rst = 1'b0;
      seq_start = 1'b0;
      seq_abort = 1'b0;
      seq_lr_valid_1 = 1'b0;
      seq_lr_valid_2 = 1'b0;
      seq_num_layers = 4'd0;
      seq_num_vectors = 4'd0;
      test_reset();
      test_random_runs();
      test_start_while_busy();
      test_timeout();
      test_zero_layers();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 Parameter W_CYCLES, default 2: cycles seq_load_weights is held per layer.
REQ-002 Parameter IN_CYCLES, default 2: cycles seq_load_inputs is held, first layer only.
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before error.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst as elsewhere in the codebase.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 seq_start  in  1  one-cycle run request.
REQ-008 seq_abort  in  1  return to IDLE.
REQ-009 seq_num_layers  in  4  layer count; latched on accepted start.
REQ-010 seq_num_vectors  in  4  result beats per layer; latched on accepted start.
REQ-011 seq_lr_valid_1  in  1  leaky relu column-1 valid.
REQ-012 seq_lr_valid_2  in  1  leaky relu column-2 valid.
REQ-013 seq_load_weights  out  1  weight-load enable.
REQ-014 seq_load_inputs  out  1  external input-load enable.
REQ-015 seq_nn_start  out  1  accumulator/systolic start pulse.
REQ-016 seq_activation_datapath  out  2  00 idle, 01 feedback, 10 output.
REQ-017 seq_layer_idx  out  4  current layer.
REQ-018 seq_busy  out  1  high outside IDLE, DONE and ERROR.
REQ-019 seq_done  out  1  one-cycle completion pulse.
REQ-020 seq_error  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD_W, LOAD_IN, START, WAIT, NEXT, DONE and ERROR, all registered.
REQ-022 IDLE: seq_start SHALL latch the config, clear seq_error and seq_layer_idx, then go to LOAD_W; if seq_num_layers==0 it SHALL go straight to DONE.
REQ-023 seq_start SHALL be ignored while seq_busy=1.
REQ-024 LOAD_W SHALL assert seq_load_weights for exactly W_CYCLES cycles, then go to LOAD_IN if layer_idx==0, else to START.
REQ-025 LOAD_IN SHALL assert seq_load_inputs for exactly IN_CYCLES cycles, then go to START.
REQ-026 START SHALL assert seq_nn_start for exactly one cycle, clear the beat and timeout counters, then go to WAIT.
REQ-027 WAIT SHALL count cycles where seq_lr_valid_2=1 and SHALL go to NEXT in the cycle after the count reaches the latched num_vectors; seq_lr_valid_1 is ignored for counting.
REQ-028 In WAIT, once the timeout counter reaches TIMEOUT with the beat target unmet, the FSM SHALL go to ERROR; seq_error SHALL be set and held until the next accepted seq_start.
REQ-029 NEXT SHALL increment seq_layer_idx, go to DONE if the new value equals num_layers, else go to LOAD_W.
REQ-030 seq_activation_datapath SHALL be 01 while layer_idx < num_layers-1, 10 on the last layer, and 00 in IDLE, DONE and ERROR.
REQ-031 DONE SHALL assert seq_done for one cycle and return to IDLE.
REQ-032 ERROR SHALL return to IDLE on the next cycle.
REQ-033 seq_abort SHALL move any state to IDLE on the next edge and deassert all enables; it takes priority over seq_start in the same cycle; it SHALL NOT pulse seq_done and SHALL leave seq_error unchanged.
REQ-034 Beat and timeout counters SHALL saturate and never wrap.
REQ-035 All outputs SHALL be registered, decoded from next state, so that enables align with state entry.

Reset
REQ-036 While rst=0, the block SHALL be in state IDLE with all outputs 0 and all counters and latched config cleared, asynchronously.
REQ-037 Reset asserted mid-run SHALL abort the run with no seq_done pulse.

Structure
REQ-038 A shared package SHALL hold the state enum and the activation_datapath encodings (ACT_IDLE, ACT_FEEDBACK, ACT_OUTPUT).
REQ-039 One sub-module, seq_counter, SHALL implement the clearable saturating counter used for phase, beat and timeout counts.

Verification
REQ-040 Layers=1, vectors=2, two valid_2 pulses: load_weights high 2 cycles, then load_inputs 2, then nn_start 1; datapath=10; seq_done after the second beat.
REQ-041 Layers=3, vectors=1: load_inputs appears only in layer 0; datapath sequence 01, 01, 10; layer_idx 0, 1, 2; one seq_done.
REQ-042 No valid pulses in WAIT: seq_error rises after 64 WAIT cycles, seq_busy falls, and the next seq_start clears seq_error.
REQ-043 seq_abort during LOAD_W or WAIT, and rst low mid-WAIT: IDLE next edge, all outputs 0, no seq_done.
REQ-044 seq_start pulsed while busy: no effect on state or latched config; seq_num_layers=0 start: seq_done pulses with no load enables.
